elelock_ctrl: RTL and testbench

Sequencing controller for the electronic lock. It divides osc_clk into a key-sampling tick and runs the PIN-entry state machine. It counts failed attempts, imposes a timed lockout after repeated failures, and drives the lock actuator. It sits between the raw ten-key/close inputs and the lock output, replacing ad-hoc shift-register matching with an explicit attempt-based controller.

---
 rtl/elelock_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_elelock_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elelock_ctrl.sv
// Electronic lock sequencer: key-sampling tick divider, PIN-entry FSM, failure lockout.
// Optional build macro ELELOCK_AUTO_RELOCK_EN enables timed relock while open.
module elelock_ctrl #(
  parameter int unsigned TICK_DIV       = 1064000,
  parameter logic [15:0] PIN            = 16'h5963,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_TICKS  = 500,
  parameter int unsigned ENTRY_TO_TICKS = 250,
  parameter int unsigned RELOCK_TICKS   = 500
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt,
  output logic       tick
);

  localparam int unsigned TW      = $clog2(TICK_DIV);
  localparam int unsigned TMR_A   = (LOCKOUT_TICKS > ENTRY_TO_TICKS) ? LOCKOUT_TICKS : ENTRY_TO_TICKS;
  localparam int unsigned TMR_MAX = (TMR_A > RELOCK_TICKS) ? TMR_A : RELOCK_TICKS;
  localparam int unsigned MW      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  logic [TW-1:0] r_div;
  logic          r_tick;
  logic          r_samp;
  logic [9:0]    r_cur;
  logic [9:0]    r_prev;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_code;
  logic [15:0]   w_code_nxt;
  logic [MW-1:0] r_tmr;
  logic [MW-1:0] w_tmr_nxt;
  logic [2:0]    r_dcnt;
  logic [2:0]    w_dcnt_nxt;
  logic [1:0]    r_fail;
  logic [1:0]    w_fail_nxt;
  logic [1:0]    w_fail_inc;
  logic          r_lock;
  logic          w_lock_nxt;
  logic          r_lockout;
  logic          w_lockout_nxt;
  logic          w_press;
  logic [3:0]    w_digit;

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] key_digit(input logic [9:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        d = 4'(i);
      end
    end
    return d;
  endfunction

  // tick is registered one count early so it is high exactly while r_div == TICK_DIV-1
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      r_div  <= {TW{1'b0}};
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == TW'(TICK_DIV - 1)) ? {TW{1'b0}} : r_div + TW'(1);
      r_tick <= (r_div == TW'(TICK_DIV - 2));
    end
  end

  // key sampler: r_samp marks the cycle right after a sampling edge
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      r_cur  <= 10'd0;
      r_prev <= 10'd0;
      r_samp <= 1'b0;
    end else begin
      r_samp <= r_tick;
      if (r_tick) begin
        r_cur  <= tenkey;
        r_prev <= r_cur;
      end
    end
  end

  assign w_press    = r_samp && (r_prev == 10'd0) && is_onehot(r_cur);
  assign w_digit    = key_digit(r_cur);
  assign w_fail_inc = (r_fail == 2'(MAX_FAIL)) ? r_fail : r_fail + 2'd1;

  // FSM state and all controller registers
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_code    <= 16'h0000;
      r_tmr     <= {MW{1'b0}};
      r_dcnt    <= 3'd0;
      r_fail    <= 2'd0;
      r_lock    <= 1'b1;
      r_lockout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_tmr     <= w_tmr_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_fail    <= w_fail_nxt;
      r_lock    <= w_lock_nxt;
      r_lockout <= w_lockout_nxt;
    end
  end

  // next-state and registered-output logic; close outranks a press in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_tmr_nxt     = r_tmr;
    w_dcnt_nxt    = r_dcnt;
    w_fail_nxt    = r_fail;
    w_lock_nxt    = r_lock;
    w_lockout_nxt = r_lockout;
    case (r_state)
      S_IDLE: begin
        w_lock_nxt = 1'b1;
        if (w_press) begin
          w_code_nxt  = {12'h000, w_digit};
          w_dcnt_nxt  = 3'd1;
          w_tmr_nxt   = {MW{1'b0}};
          w_state_nxt = S_ENTRY;
        end else begin
          w_dcnt_nxt = 3'd0;
        end
      end
      S_ENTRY: begin
        if (close) begin
          w_dcnt_nxt  = 3'd0;
          w_state_nxt = S_IDLE;
        end else if (w_press) begin
          w_code_nxt = {r_code[11:0], w_digit};
          w_dcnt_nxt = r_dcnt + 3'd1;
          w_tmr_nxt  = {MW{1'b0}};
          if (r_dcnt == 3'd3) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_state_nxt = S_ENTRY;
          end
        end else if (r_tick) begin
          if (r_tmr == MW'(ENTRY_TO_TICKS - 1)) begin
            w_dcnt_nxt  = 3'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_tmr_nxt = r_tmr + MW'(1);
          end
        end else begin
          w_tmr_nxt = r_tmr;
        end
      end
      S_CHECK: begin
        w_dcnt_nxt = 3'd0;
        w_tmr_nxt  = {MW{1'b0}};
        if (r_code == PIN) begin
          w_fail_nxt  = 2'd0;
          w_lock_nxt  = 1'b0;
          w_state_nxt = S_OPEN;
        end else begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc == 2'(MAX_FAIL)) begin
            w_lockout_nxt = 1'b1;
            w_state_nxt   = S_LOCKOUT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (close) begin
          w_lock_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
`ifdef ELELOCK_AUTO_RELOCK_EN
        end else if (r_tick) begin
          if (r_tmr == MW'(RELOCK_TICKS - 1)) begin
            w_lock_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_tmr_nxt = r_tmr + MW'(1);
          end
`endif
        end else begin
          w_lock_nxt = 1'b0;
        end
      end
      S_LOCKOUT: begin
        if (r_tick) begin
          if (r_tmr == MW'(LOCKOUT_TICKS - 1)) begin
            w_lockout_nxt = 1'b0;
            w_fail_nxt    = 2'd0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_tmr_nxt = r_tmr + MW'(1);
          end
        end else begin
          w_lockout_nxt = 1'b1;
        end
      end
      default: begin
        w_lock_nxt    = 1'b1;
        w_lockout_nxt = 1'b0;
        w_dcnt_nxt    = 3'd0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  assign lock      = r_lock;
  assign lockout   = r_lockout;
  assign fail_cnt  = r_fail;
  assign digit_cnt = r_dcnt;
  assign tick      = r_tick;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Bench for elelock_ctrl: vector table, directed corner sequences and random keys
// checked every cycle against a digit-queue reference model.
module tb_elelock_ctrl;
  localparam int TD   = 4;
  localparam int LT   = 20;
  localparam int ET   = 12;
  localparam int RT   = 8;
  localparam int MAXF = 3;

  logic       osc_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] tenkey  = 10'd0;
  logic       close   = 1'b0;
  logic       lock, lockout, tick;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  elelock_ctrl #(
    .TICK_DIV(TD), .PIN(16'h5963), .MAX_FAIL(MAXF),
    .LOCKOUT_TICKS(LT), .ENTRY_TO_TICKS(ET), .RELOCK_TICKS(RT)
  ) dut (
    .osc_clk(osc_clk), .reset(reset), .tenkey(tenkey), .close(close),
    .lock(lock), .lockout(lockout), .fail_cnt(fail_cnt),
    .digit_cnt(digit_cnt), .tick(tick)
  );

  always #5 osc_clk = ~osc_clk;

  // reference model: digits typed so far, plus mode flags and a tick timer
  int         m_phase;
  logic [9:0] m_sample;
  int         m_pdig;
  int         m_digits[$];
  bit         m_checking, m_open, m_lockout;
  int         m_fail, m_timer;

  task automatic model_reset();
    m_phase = 0; m_sample = 10'd0; m_pdig = -1; m_digits.delete();
    m_checking = 1'b0; m_open = 1'b0; m_lockout = 1'b0; m_fail = 0; m_timer = 0;
  endtask

  function automatic bit pin_match();
    return m_digits.size() == 4 && m_digits[0] == 5 && m_digits[1] == 9 &&
           m_digits[2] == 6 && m_digits[3] == 3;
  endfunction

  task automatic model_step();
    bit tk;
    bit ok;
    int pd;
    tk = (m_phase == TD - 1);
    pd = m_pdig;
    if (m_checking) begin
      ok = pin_match();
      m_checking = 1'b0; m_digits.delete(); m_timer = 0;
      if (ok) begin
        m_open = 1'b1; m_fail = 0;
      end else begin
        if (m_fail < MAXF) m_fail++;
        if (m_fail == MAXF) m_lockout = 1'b1;
      end
    end else if (m_lockout) begin
      if (tk) begin
        m_timer++;
        if (m_timer == LT) begin m_lockout = 1'b0; m_fail = 0; end
      end
    end else if (m_open) begin
      if (close) m_open = 1'b0;
`ifdef ELELOCK_AUTO_RELOCK_EN
      else if (tk) begin
        m_timer++;
        if (m_timer == RT) m_open = 1'b0;
      end
`endif
    end else if (m_digits.size() > 0) begin
      if (close) m_digits.delete();
      else if (pd >= 0) begin
        m_digits.push_back(pd); m_timer = 0;
        if (m_digits.size() == 4) m_checking = 1'b1;
      end else if (tk) begin
        m_timer++;
        if (m_timer == ET) m_digits.delete();
      end
    end else if (pd >= 0) begin
      m_digits.push_back(pd); m_timer = 0;
    end
    if (tk) begin
      m_pdig   = (m_sample == 10'd0 && $countones(tenkey) == 1) ? $clog2(tenkey) : -1;
      m_sample = tenkey;
    end else begin
      m_pdig = -1;
    end
    m_phase = (m_phase + 1) % TD;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // one clock: advance model, let the edge pass, compare every output
  task automatic cyc();
    logic [7:0] act;
    logic [7:0] exp;
    model_step();
    @(posedge osc_clk);
    #1;
    act = {lock, lockout, fail_cnt, digit_cnt, tick};
    exp = {~m_open, m_lockout, 2'(m_fail), 3'(m_digits.size()), (m_phase == TD - 1)};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL cycle {lock,lockout,fail,digits,tick}: got %b, expected %b (t=%0t)",
                  act, exp, $time);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic key(input int d, input int hold, input int rel);
    tenkey = 10'b1 << d;
    run(hold);
    tenkey = 10'd0;
    run(rel);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    key(a, 8, 8); key(b, 8, 8); key(c, 8, 8); key(d, 8, 8);
  endtask

  // asynchronous reset mid-cycle: outputs must return to reset values at once
  task automatic reset_check(input string nm);
    tenkey = 10'd0; close = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk({nm, "_lock"}, int'(lock), 1);
    chk({nm, "_lockout"}, int'(lockout), 0);
    chk({nm, "_fail"}, int'(fail_cnt), 0);
    chk({nm, "_digits"}, int'(digit_cnt), 0);
    chk({nm, "_tick"}, int'(tick), 0);
    @(posedge osc_clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [9:0] keys;
    int         hold;
    int         rel;
    bit         cls;
    int         e_lock;
    int         e_lockout;
    int         e_fail;
    int         e_dcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [9:0] k, input int h, input int r, input bit c,
                              input int el, input int elo, input int ef, input int ed);
    vec_t v;
    v.keys = k; v.hold = h; v.rel = r; v.cls = c;
    v.e_lock = el; v.e_lockout = elo; v.e_fail = ef; v.e_dcnt = ed;
    vecs.push_back(v);
  endfunction

  function automatic logic [9:0] kb(input int d);
    return 10'b1 << d;
  endfunction

  initial begin
    int n;
    model_reset();
    // correct PIN, then close
    add(kb(5), 8, 8, 1'b0, 1, 0, 0, 1);
    add(kb(9), 8, 8, 1'b0, 1, 0, 0, 2);
    add(kb(6), 8, 8, 1'b0, 1, 0, 0, 3);
    add(kb(3), 8, 8, 1'b0, 0, 0, 0, 0);
    add(10'd0, 1, 0, 1'b1, 1, 0, 0, 0);
    // three wrong attempts -> lockout
    for (int a = 1; a <= 3; a++) begin
      add(kb(1), 8, 8, 1'b0, 1, 0, a - 1, 1);
      add(kb(2), 8, 8, 1'b0, 1, 0, a - 1, 2);
      add(kb(3), 8, 8, 1'b0, 1, 0, a - 1, 3);
      add(kb(4), 8, 8, 1'b0, 1, (a == 3) ? 1 : 0, a, 0);
    end
    // PIN ignored during lockout, then lockout expires
    add(kb(5), 8, 8, 1'b0, 1, 1, 3, 0);
    add(kb(9), 8, 8, 1'b0, 1, 1, 3, 0);
    add(kb(6), 8, 8, 1'b0, 1, 1, 3, 0);
    add(kb(3), 8, 8, 1'b0, 1, 1, 3, 0);
    add(10'd0, 0, 24, 1'b0, 1, 0, 0, 0);
    add(kb(5), 8, 8, 1'b0, 1, 0, 0, 1);
    add(kb(9), 8, 8, 1'b0, 1, 0, 0, 2);
    add(kb(6), 8, 8, 1'b0, 1, 0, 0, 3);
    add(kb(3), 8, 8, 1'b0, 0, 0, 0, 0);
    add(10'd0, 1, 0, 1'b1, 1, 0, 0, 0);
    // inter-key timeout discards digits without counting a failure
    add(kb(5), 8, 8, 1'b0, 1, 0, 0, 1);
    add(kb(9), 8, 8, 1'b0, 1, 0, 0, 2);
    add(10'd0, 0, (ET + 1) * TD, 1'b0, 1, 0, 0, 0);
    add(kb(5), 8, 8, 1'b0, 1, 0, 0, 1);
    add(kb(9), 8, 8, 1'b0, 1, 0, 0, 2);
    add(kb(6), 8, 8, 1'b0, 1, 0, 0, 3);
    add(kb(3), 8, 8, 1'b0, 0, 0, 0, 0);
    add(10'd0, 1, 0, 1'b1, 1, 0, 0, 0);
    // two keys at once give no event; a key held over 3 ticks gives one
    add(kb(5) | kb(9), 8, 8, 1'b0, 1, 0, 0, 0);
    add(kb(7), 12, 8, 1'b0, 1, 0, 0, 1);
    add(10'd0, 0, (ET + 1) * TD, 1'b0, 1, 0, 0, 0);

    repeat (2) @(posedge osc_clk);
    #1;
    chk("reset_lock", int'(lock), 1);
    chk("reset_lockout", int'(lockout), 0);
    chk("reset_fail", int'(fail_cnt), 0);
    chk("reset_digits", int'(digit_cnt), 0);
    chk("reset_tick", int'(tick), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tenkey = vecs[i].keys; close = vecs[i].cls;
      run(vecs[i].hold);
      tenkey = 10'd0; close = 1'b0;
      run(vecs[i].rel);
      chk($sformatf("vec%0d_lock", i), int'(lock), vecs[i].e_lock);
      chk($sformatf("vec%0d_lockout", i), int'(lockout), vecs[i].e_lockout);
      chk($sformatf("vec%0d_fail", i), int'(fail_cnt), vecs[i].e_fail);
      chk($sformatf("vec%0d_digits", i), int'(digit_cnt), vecs[i].e_dcnt);
    end

    // unlock latency: one cycle in CHECK, lock falls on the following edge
    key(5, 8, 8); key(9, 8, 8); key(6, 8, 8);
    tenkey = kb(3);
    n = 0;
    while (digit_cnt != 3'd4 && n < 40) begin cyc(); n++; end
    chk("check_reached", int'(digit_cnt), 4);
    cyc();
    chk("unlock_latency", int'(lock), 0);
    tenkey = 10'd0;
`ifdef ELELOCK_AUTO_RELOCK_EN
    run(RT * TD + TD);
    chk("auto_relock", int'(lock), 1);
`else
    run(100 * TD);
    chk("stays_open", int'(lock), 0);
    close = 1'b1; cyc(); close = 1'b0;
    chk("close_relock", int'(lock), 1);
`endif

    // reset with a failure recorded and three digits pending
    enter4(1, 2, 3, 4);
    key(1, 8, 8); key(2, 8, 8); key(3, 8, 8);
    chk("pre_reset_digits", int'(digit_cnt), 3);
    chk("pre_reset_fail", int'(fail_cnt), 1);
    reset_check("rst_entry");
    // reset during lockout
    enter4(1, 2, 3, 4); enter4(1, 2, 3, 4); enter4(1, 2, 3, 4);
    chk("pre_reset_lockout", int'(lockout), 1);
    reset_check("rst_lockout");
    // reset while open
    enter4(5, 9, 6, 3);
    chk("pre_reset_open", int'(lock), 0);
    reset_check("rst_open");

    // random traffic against the model
    for (int e = 0; e < 400; e++) begin
      n = $urandom_range(0, 9);
      if (n < 3) begin
        key(5, $urandom_range(4, 12), $urandom_range(4, 10));
        key(9, $urandom_range(4, 12), $urandom_range(4, 10));
        key(6, $urandom_range(4, 12), $urandom_range(4, 10));
        key(3, $urandom_range(4, 12), $urandom_range(4, 10));
      end else if (n < 7) begin
        tenkey = kb($urandom_range(0, 9));
        close = ($urandom_range(0, 7) == 0);
        run($urandom_range(1, 12));
        close = 1'b0;
        if ($urandom_range(0, 3) != 0) tenkey = 10'd0;
        run($urandom_range(0, 10));
        tenkey = 10'd0;
      end else if (n == 7) begin
        tenkey = 10'($urandom_range(0, 1023));
        run($urandom_range(1, 10));
        tenkey = 10'd0;
        run($urandom_range(0, 8));
      end else if (n == 8) begin
        close = 1'b1;
        run($urandom_range(1, 3));
        close = 1'b0;
      end else begin
        run($urandom_range(0, 40));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
